fetch_unit: RTL and testbench

//   Instruction-fetch stage directly upstream of the multicycle control FSM.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the multicycle control FSM.
// Holds the program counter, reads instruction memory at pc, and presents a
// stable registered instruction word plus its 3-bit opcode.
// Optional feature macro: FETCH_BRANCH_EN (honour branch_taken/branch_target).
module fetch_unit #(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 9,
  parameter int                 MEM_LAT   = 1,
  parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               next_ins,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [2:0]         opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // MEM_LAT is at most 3, so a 2-bit countdown covers every legal setting.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [1:0]         lat_r, lat_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic               valid_r, valid_s;
  logic               done_r, done_s;
  logic               ovr_r, ovr_s;
  logic [PC_W-1:0]    pc_next_s;

`ifdef FETCH_BRANCH_EN
  // Sequential successor: branch target when taken, otherwise pc+1 (wraps).
  assign pc_next_s = branch_taken ? branch_target : pc_r + PC_W'(1);
`else
  // Branch ports exist for a uniform interface but have no effect here.
  logic unused_branch_s;
  assign unused_branch_s = ^{branch_taken, branch_target};
  assign pc_next_s       = pc_r + PC_W'(1);
`endif

  // Next-state and next-datapath logic; start has priority over everything.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    lat_s   = lat_r;
    instr_s = instr_r;
    valid_s = valid_r;
    done_s  = done_r;
    ovr_s   = ovr_r;
    if (start) begin
      state_s = FETCH;
      pc_s    = {PC_W{1'b0}};
      lat_s   = LAT_INIT;
      valid_s = 1'b0;
      done_s  = 1'b0;
      ovr_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (next_ins) begin
            ovr_s = 1'b1;
          end else begin
            ovr_s = ovr_r;
          end
        end
        FETCH: begin
          if (next_ins) begin
            ovr_s = 1'b1;
          end else begin
            ovr_s = ovr_r;
          end
          if (lat_r <= 2'd1) begin
            // Final fetch cycle: capture the word and decide HOLD vs HALT.
            instr_s = imem_rdata;
            valid_s = 1'b1;
            if (imem_rdata == HALT_WORD) begin
              done_s  = 1'b1;
              state_s = HALT;
            end else begin
              state_s = HOLD;
            end
          end else begin
            lat_s = lat_r - 2'd1;
          end
        end
        HOLD: begin
          if (next_ins) begin
            pc_s    = pc_next_s;
            valid_s = 1'b0;
            lat_s   = LAT_INIT;
            state_s = FETCH;
          end else begin
            state_s = HOLD;
          end
        end
        HALT: begin
          state_s = HALT;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      pc_r    <= {PC_W{1'b0}};
      lat_r   <= 2'd0;
      instr_r <= {INSTR_W{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      lat_r   <= lat_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      ovr_r   <= ovr_s;
    end
  end

  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instruction = instr_r;
  assign opcode      = instr_r[INSTR_W-1 -: 3];
  assign instr_valid = valid_r;
  assign done        = done_r;
  assign overrun     = ovr_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (MEM_LAT=2).
// Expected values come from a high-level model: a memory array, an expected
// pc computed from the fetch rules, and halt detection on the fetched word.
module tb_fetch_unit;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int MEM_LAT = 2;
  localparam logic [INSTR_W-1:0] HALT = 9'h1FF;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               next_ins = 1'b0;
  logic               branch_taken = 1'b0;
  logic [PC_W-1:0]    branch_target = '0;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic [2:0]         opcode;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               done;
  logic               overrun;

  logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
  logic [PC_W-1:0]    exp_pc;
  int n_cmp = 0;
  int n_err = 0;

  assign imem_rdata = mem[imem_addr];

  always #5 clock = ~clock;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_LAT(MEM_LAT), .HALT_WORD(HALT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .next_ins(next_ins),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
    .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .done(done), .overrun(overrun)
  );

  // Expected pc after a retire in HOLD, straight from the fetch rules.
  function automatic logic [PC_W-1:0] model_next(input logic [PC_W-1:0] cur, input logic br,
                                                 input logic [PC_W-1:0] tgt);
    int nxt;
`ifdef FETCH_BRANCH_EN
    if (br) nxt = int'(tgt);
    else    nxt = (int'(cur) + 1) % (1 << PC_W);
`else
    nxt = (int'(cur) + 1) % (1 << PC_W);
`endif
    return nxt[PC_W-1:0];
  endfunction

  // Stimulus: one-cycle start pulse; returns #1 after the sampling edge.
  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  // Stimulus: one-cycle next_ins pulse; returns #1 after the sampling edge.
  task automatic pulse_next(input logic br, input logic [PC_W-1:0] tgt);
    @(negedge clock); next_ins = 1'b1; branch_taken = br; branch_target = tgt;
    @(posedge clock); #1 next_ins = 1'b0; branch_taken = 1'b0;
  endtask

  // Stimulus: wait out the remaining fetch edges so the capture edge has passed.
  task automatic wait_lat();
    repeat (MEM_LAT) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({pc, instr_valid, done, overrun, instruction} !== '0) begin
      n_err++; $display("FAIL reset_state got pc=%h v=%b d=%b o=%b i=%h required all zero", pc, instr_valid, done, overrun, instruction);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    pulse_start();
    n_cmp++; if (instr_valid !== 1'b0 || pc !== 10'h000) begin
      n_err++; $display("FAIL start_edge1 got v=%b pc=%h required v=0 pc=000", instr_valid, pc);
    end
    @(posedge clock); #1;
    n_cmp++; if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL start_edge2 got v=%b required 0", instr_valid);
    end
    @(posedge clock); #1;
    n_cmp++; if (instr_valid !== 1'b1 || opcode !== 3'b001 || instruction !== 9'h041) begin
      n_err++; $display("FAIL start_edge3 got v=%b op=%b i=%h required v=1 op=001 i=041", instr_valid, opcode, instruction);
    end
    exp_pc = 10'h000;
  endtask

  task automatic test_branch();
    for (int i = 0; i < 5; i++) begin
      pulse_next(1'b0, '0); wait_lat();
      exp_pc = model_next(exp_pc, 1'b0, '0);
    end
    n_cmp++; if (pc !== 10'h005 || instruction !== mem[5]) begin
      n_err++; $display("FAIL hold_pc5 got pc=%h i=%h required pc=005 i=%h", pc, instruction, mem[5]);
    end
    pulse_next(1'b1, 10'h3F0);
    exp_pc = model_next(exp_pc, 1'b1, 10'h3F0);
    n_cmp++; if (pc !== exp_pc || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL branch_pc got pc=%h v=%b required pc=%h v=0", pc, instr_valid, exp_pc);
    end
    wait_lat();
    n_cmp++; if (instruction !== mem[exp_pc] || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL branch_fetch got i=%h v=%b required i=%h v=1", instruction, instr_valid, mem[exp_pc]);
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (exp_pc != 10'h3FF && guard < 1100) begin
      pulse_next(1'b1, 10'h3FF); wait_lat();
      exp_pc = model_next(exp_pc, 1'b1, 10'h3FF);
      guard++;
    end
    n_cmp++; if (pc !== 10'h3FF) begin
      n_err++; $display("FAIL reach_3ff got pc=%h required 3ff", pc);
    end
    pulse_next(1'b0, '0); wait_lat();
    n_cmp++; if (pc !== 10'h000 || instruction !== 9'h041 || imem_addr !== 10'h000) begin
      n_err++; $display("FAIL wrap got pc=%h i=%h required pc=000 i=041", pc, instruction);
    end
    exp_pc = 10'h000;
  endtask

  task automatic test_overrun();
    pulse_next(1'b0, '0);
    exp_pc = model_next(exp_pc, 1'b0, '0);
    pulse_next(1'b0, '0);
    n_cmp++; if (overrun !== 1'b1 || pc !== exp_pc) begin
      n_err++; $display("FAIL overrun_set got o=%b pc=%h required o=1 pc=%h", overrun, pc, exp_pc);
    end
    @(posedge clock); #1;
    n_cmp++; if (overrun !== 1'b1 || instr_valid !== 1'b1 || pc !== exp_pc) begin
      n_err++; $display("FAIL overrun_sticky got o=%b v=%b pc=%h required o=1 v=1 pc=%h", overrun, instr_valid, pc, exp_pc);
    end
    pulse_start();
    n_cmp++; if (overrun !== 1'b0 || pc !== 10'h000) begin
      n_err++; $display("FAIL overrun_clear got o=%b pc=%h required o=0 pc=000", overrun, pc);
    end
    wait_lat();
    exp_pc = 10'h000;
  endtask

  task automatic test_reset_mid_fetch();
    pulse_next(1'b0, '0);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if ({pc, instr_valid, done, overrun} !== '0) begin
      n_err++; $display("FAIL reset_mid_fetch got pc=%h v=%b d=%b o=%b required all zero", pc, instr_valid, done, overrun);
    end
    @(negedge clock); reset_n = 1'b1;
    pulse_start(); wait_lat();
    exp_pc = 10'h000;
  endtask

  task automatic test_halt();
    mem[3] = HALT;
    for (int i = 0; i < 3; i++) begin
      pulse_next(1'b0, '0); wait_lat();
      exp_pc = model_next(exp_pc, 1'b0, '0);
    end
    n_cmp++; if (done !== 1'b1 || instr_valid !== 1'b1 || instruction !== HALT || pc !== 10'h003) begin
      n_err++; $display("FAIL halt got d=%b v=%b i=%h pc=%h required d=1 v=1 i=1ff pc=003", done, instr_valid, instruction, pc);
    end
    pulse_next(1'b1, 10'h100); pulse_next(1'b0, '0); wait_lat();
    n_cmp++; if (pc !== 10'h003 || overrun !== 1'b0 || done !== 1'b1 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL halt_ignore got pc=%h o=%b d=%b v=%b required pc=003 o=0 d=1 v=1", pc, overrun, done, instr_valid);
    end
  endtask

  task automatic test_random();
    logic halted = 1'b1;
    logic br;
    logic [PC_W-1:0] tgt;
    for (int i = 0; i < 40; i++) begin
      if (halted) begin
        pulse_start(); exp_pc = 10'h000;
      end else begin
        br  = 1'($urandom_range(0, 1));
        tgt = PC_W'($urandom_range(0, (1 << PC_W) - 1));
        pulse_next(br, tgt);
        exp_pc = model_next(exp_pc, br, tgt);
      end
      n_cmp++; if (pc !== exp_pc || instr_valid !== 1'b0) begin
        n_err++; $display("FAIL rand_pc[%0d] got pc=%h v=%b required pc=%h v=0", i, pc, instr_valid, exp_pc);
      end
      wait_lat();
      halted = (mem[exp_pc] == HALT);
      n_cmp++; if (instruction !== mem[exp_pc] || instr_valid !== 1'b1 || done !== halted) begin
        n_err++; $display("FAIL rand_fetch[%0d] got i=%h v=%b d=%b required i=%h v=1 d=%b", i, instruction, instr_valid, done, mem[exp_pc], halted);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << PC_W); a++) mem[a] = INSTR_W'($urandom_range(0, 9'h1FE));
    mem[0] = 9'h041;
    exp_pc = '0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_wrap();
    test_overrun();
    test_reset_mid_fetch();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
